// File: rtl/sdram_pattern_tester.sv
`default_nettype none
// ============================================================================
// sdram_pattern_tester : write-then-read-compare tester for an SDRAM controller
// Revision 1.0 - initial release
// ============================================================================
module sdram_pattern_tester #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4194304,
  parameter int BASE   = 0,
  parameter int ERR_W  = 16,
  parameter int PASS_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic [31:0]         i_seed,
  input  logic                i_continuous,
  input  logic                i_stop,
  input  logic                i_wait_req,
  input  logic                i_valid,
  input  logic [DATA_W-1:0]   i_data,
  output logic                o_rd_n,
  output logic                o_wr_n,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [DATA_W-1:0]   o_data,
  output logic [DATA_W/8-1:0] o_be_n,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [ERR_W-1:0]    o_err_count,
  output logic [ADDR_W-1:0]   o_first_err_addr,
  output logic [DATA_W-1:0]   o_first_err_data,
  output logic [PASS_W-1:0]   o_pass_count
);

  localparam int                BP_W       = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE + DEPTH - 1);
  localparam logic [BP_W-1:0]   LAST_BIT   = BP_W'(DATA_W - 1);
  localparam logic [31:0]       LFSR_TAPS  = 32'h8020_0003;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_REQ   = 3'd1;
  localparam logic [2:0] RD_REQ   = 3'd2;
  localparam logic [2:0] RD_WAIT  = 3'd3;
  localparam logic [2:0] RD_CHECK = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]        state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [31:0]       lfsr, lfsr_next, seed, seed_in;
  logic [BP_W-1:0]   bitpos, bitpos_next;
  logic [1:0]        mode;
  logic              continuous, stop_pend, captured;
  logic [DATA_W-1:0] rdata, pattern;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;
  logic [PASS_W-1:0] pass_count;
  logic              wr_acc, rd_acc, last, mismatch;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  assign wr_acc   = (state == WR_REQ) && !i_wait_req;
  assign rd_acc   = (state == RD_REQ) && !i_wait_req;
  assign last     = (addr == LAST_ADDR);
  assign mismatch = (rdata != pattern);
  assign seed_in  = (i_seed == 32'h0) ? 32'h1 : i_seed;

  // Both passes share one walk: the last word rewinds address, LFSR and bit index.
  always_comb begin
    addr_next   = last ? FIRST_ADDR : addr + 1'b1;
    lfsr_next   = last ? seed : lfsr_step(lfsr);
    bitpos_next = (last || bitpos == LAST_BIT) ? '0 : bitpos + 1'b1;
  end

  always_comb begin
    case (mode)
      2'd0:    pattern = DATA_W'(addr);
      2'd1:    pattern = ~DATA_W'(addr);
      2'd2:    pattern = lfsr[DATA_W-1:0];
      default: pattern = DATA_W'(1) << bitpos;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (i_start) state_next = WR_REQ;
      WR_REQ: begin
        if (wr_acc) begin
          if (i_stop)    state_next = DONE;
          else if (last) state_next = RD_REQ;
        end
      end
      RD_REQ:  if (rd_acc)  state_next = RD_WAIT;
      RD_WAIT: if (i_valid) state_next = RD_CHECK;
      RD_CHECK: begin
        if (i_stop || stop_pend) state_next = DONE;
        else if (last)           state_next = continuous ? WR_REQ : DONE;
        else                     state_next = RD_REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_wr_n           = (state != WR_REQ);
    o_rd_n           = (state != RD_REQ);
    o_data           = (state == WR_REQ) ? pattern : '0;
    o_addr           = addr;
    o_be_n           = '0;
    o_busy           = (state != IDLE) && (state != DONE);
    o_done           = (state == DONE);
    o_error          = (err_count != '0);
    o_err_count      = err_count;
    o_first_err_addr = first_err_addr;
    o_first_err_data = first_err_data;
    o_pass_count     = pass_count;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr           <= FIRST_ADDR;
      lfsr           <= 32'h0;
      seed           <= 32'h0;
      bitpos         <= '0;
      mode           <= 2'd0;
      continuous     <= 1'b0;
      stop_pend      <= 1'b0;
      captured       <= 1'b0;
      rdata          <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass_count     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            mode           <= i_mode;
            seed           <= seed_in;
            lfsr           <= seed_in;
            continuous     <= i_continuous;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            captured       <= 1'b0;
            stop_pend      <= 1'b0;
            addr           <= FIRST_ADDR;
            bitpos         <= '0;
          end
        end
        WR_REQ: begin
          if (wr_acc) begin
            addr   <= addr_next;
            lfsr   <= lfsr_next;
            bitpos <= bitpos_next;
          end
        end
        RD_REQ:  if (rd_acc)  stop_pend <= i_stop;
        RD_WAIT: if (i_valid) rdata <= i_data;
        RD_CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!captured) begin
              first_err_addr <= addr;
              first_err_data <= rdata;
            end
            captured <= 1'b1;
          end
          if (last) pass_count <= pass_count + 1'b1;
          stop_pend <= 1'b0;
          addr      <= addr_next;
          lfsr      <= lfsr_next;
          bitpos    <= bitpos_next;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
